dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter AW, default 6, meaning the word-index width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port rd, input, 1 bit: read request, sampled in IDLE.
REQ-006 The block SHALL have port wr, input, 1 bit: write request, sampled in IDLE.
REQ-007 The block SHALL have port dir, input, 32 bits: byte address from the ALU result.
REQ-008 The block SHALL have port dataIn, input, 32 bits: write data from register-file read port 2.
REQ-009 The block SHALL have port dataOut, output, 32 bits: read data to the write-back mux.
REQ-010 The block SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a request is in flight.
REQ-012 The block SHALL have port err, output, 1 bit: error flag, valid with ack.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-014 In IDLE with rd|wr=1 at edge T, the request (rd, wr, dir, dataIn) SHALL be latched and the FSM SHALL move to ACCESS; with rd=wr=0 it SHALL stay in IDLE.
REQ-015 In ACCESS, a valid write SHALL update word dir[AW+1:2], and a valid read SHALL capture that word into the dataOut register; the FSM SHALL then move to RESP unconditionally.
REQ-016 In RESP, ack=1 for exactly one cycle, then the FSM SHALL return to IDLE; ack is therefore high during cycle T+2.
REQ-017 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.
REQ-018 rd/wr asserted while busy=1 SHALL be ignored, not queued; maximum throughput is one request per 3 cycles.
REQ-019 dataOut SHALL change only on completion of a valid read and SHALL hold its value otherwise, including across writes and errors.
REQ-020 A request SHALL be an error if: rd=wr=1 simultaneously; dir[1:0]!=0 (misaligned); or dir >= 4*DEPTH (out of range).
REQ-021 An error request SHALL perform no array access, SHALL still complete with ack at T+2, and SHALL drive err=1 in that cycle.
REQ-022 err SHALL be 0 whenever ack=0, and 0 on good completions.
REQ-023 Read-after-write to the same address SHALL return the written data; back-to-back requests are separated by the 3-cycle turnaround.
REQ-024 Address arithmetic SHALL be unsigned; dir[31:AW+2] must be zero for a valid request.

Reset
REQ-025 Asserting rst SHALL asynchronously force state=IDLE, ack=0, busy=0, err=0 and dataOut=32'd0.
REQ-026 A reset asserted mid-operation SHALL abort the request; a write not yet performed in ACCESS SHALL NOT occur, and no ack SHALL follow.
REQ-027 Array contents SHALL NOT be reset; benches SHALL write a location before reading it.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/ACCESS/RESP) and the DEPTH/AW defaults.
REQ-029 Storage SHALL be a sub-module dmem_array with synchronous write and registered read, instanced once; the FSM, request latch and error check stay in dmem_responder.

Verification
REQ-030 Write then read: wr, dir=0x8, dataIn=0xDEADBEEF, then rd, dir=0x8 -> both acks at T+2, err=0, dataOut=0xDEADBEEF after the read ack.
REQ-031 Misaligned read: rd, dir=0x6 -> ack at T+2, err=1, dataOut unchanged.
REQ-032 Out-of-range write: wr, dir=0x100, dataIn=0x1234 (DEPTH=64) -> err=1 ack; a later read of 0x0 returns its prior value.
REQ-033 Conflicting request: rd=wr=1, dir=0x4 -> err=1 ack; word 1 unchanged.
REQ-034 Busy drop: request at T, new rd at T+1 -> exactly one ack at T+2, and the second request is not serviced.
REQ-035 Reset mid-write: wr dir=0xC dataIn=0x55, rst pulse while in ACCESS before the edge -> no ack, busy=0, dataOut=0, and word 3 keeps its old value.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder:
//     - default geometry (DMEM_DEPTH_DEF words, DMEM_AW_DEF index bits)
//     - responder FSM state enum (IDLE / ACCESS / RESP)
//     - latched request record
//     - request error classification helper
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   localparam int unsigned DMEM_DEPTH_DEF = 64;
   localparam int unsigned DMEM_AW_DEF    = 6;
   localparam int unsigned DMEM_DATA_W    = 32;

   // Responder FSM states. The encoding is fixed so that a debugger or a
   // checker reading the raw state bits sees stable values.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } dmem_state_e;

   // One request as captured in IDLE.
   typedef struct packed {
      logic                   rd;
      logic                   wr;
      logic [DMEM_DATA_W-1:0] dir;
      logic [DMEM_DATA_W-1:0] data;
   } dmem_req_t;

   // A request is rejected when it asks for both a read and a write, when
   // the byte address is not word aligned, or when the word index falls
   // outside the array. The range test compares the full word index so that
   // any set bit above the index field also counts as out of range.
   function automatic logic req_is_err(input dmem_req_t req,
                                       input int unsigned depth);
      logic [DMEM_DATA_W-1:0] word_idx;
      word_idx = {2'b00, req.dir[DMEM_DATA_W-1:2]};
      return (req.rd & req.wr)
           | (req.dir[1:0] != 2'b00)
           | (word_idx >= depth[DMEM_DATA_W-1:0]);
   endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//   Word-addressed storage for the responder.
//   Synchronous write, registered read. The storage words are not reset; only
//   the read-data register is, so the responder's dataOut comes up as zero.
//
// Ports
//   clk_i    : clock, all updates on the rising edge
//   rst_i    : asynchronous active-high reset of the read-data register only
//   we_i     : write word addr_i with wdata_i at this edge
//   re_i     : capture word addr_i into the read-data register at this edge
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : read-data register; holds its value while re_i is low
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
   parameter int unsigned AW    = DMEM_AW_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   we_i,
   input  logic                   re_i,
   input  logic [AW-1:0]          addr_i,
   input  logic [DMEM_DATA_W-1:0] wdata_i,
   output logic [DMEM_DATA_W-1:0] rdata_o
);

   logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
   logic [DMEM_DATA_W-1:0] rdata_q;

   // Storage has no reset: its contents survive a responder reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // The read register only moves on a granted read, so it keeps the last
   // read value through writes, rejected requests and idle cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for a simple CPU load/store path. Accepts one read
//   or write request at a time, performs it against a dmem_array instance and
//   signals completion with a one-cycle ack.
//
// Handshake
//   A request is offered by raising rd or wr; it is taken at the rising edge
//   where the responder is IDLE (busy=0). While busy=1, rd/wr are ignored and
//   nothing is queued. Every taken request completes with ack=1 for exactly one
//   cycle, two edges after it was taken; err is meaningful only while ack=1.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : asynchronous active-high reset (aborts any request in flight)
//   rd      : read request, sampled in IDLE
//   wr      : write request, sampled in IDLE
//   dir     : byte address
//   dataIn  : write data
//   dataOut : read data register, updated only by a successful read
//   ack     : one-cycle completion pulse
//   busy    : high while a request is in flight (ACCESS or RESP)
//   err     : request rejected (conflict, misaligned, out of range); with ack
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
   parameter int unsigned AW    = DMEM_AW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd,
   input  logic                   wr,
   input  logic [DMEM_DATA_W-1:0] dir,
   input  logic [DMEM_DATA_W-1:0] dataIn,
   output logic [DMEM_DATA_W-1:0] dataOut,
   output logic                   ack,
   output logic                   busy,
   output logic                   err
);

   dmem_state_e state_q, state_d;
   dmem_req_t   req_q,   req_d;
   logic        err_q,   err_d;

   logic        req_err;
   logic        mem_we;
   logic        mem_re;

   // Classification is done on the latched request, so inputs changing after
   // the request edge cannot affect the outcome.
   assign req_err = req_is_err(req_q, DEPTH);

   // The array is touched only in ACCESS and only for a well-formed request.
   assign mem_we = (state_q == ST_ACCESS) & req_q.wr & ~req_err;
   assign mem_re = (state_q == ST_ACCESS) & req_q.rd & ~req_err;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rd | wr) begin
               req_d.rd   = rd;
               req_d.wr   = wr;
               req_d.dir  = dir;
               req_d.data = dataIn;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            err_d   = req_err;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .addr_i  (req_q.dir[AW+1:2]),
      .wdata_i (req_q.data),
      .rdata_o (dataOut)
   );

   // Outputs are decoded from registered state only, so they are glitch-free
   // and all fall to zero immediately on reset.
   assign ack  = (state_q == ST_RESP);
   assign busy = (state_q != ST_IDLE);
   assign err  = ack & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] dir;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ack;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd      (rd),
    .wr      (wr),
    .dir     (dir),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .ack     (ack),
    .busy    (busy),
    .err     (err)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_dout;
  int          written[$];
  logic [32:0] exp_q[$];   // {err, dataOut} expected at each ack

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_is_err(input bit r, input bit w, input logic [31:0] a);
    return (r && w) || (a % 4 != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  // Reference model: applies a request's effect and queues the expected response.
  task automatic model_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit e;
    int idx;
    e   = ref_is_err(r, w, a);
    idx = int'(a / 4);
    if (!e && w) begin
      ref_mem[idx] = d;
      written.push_back(idx);
    end
    if (!e && r) ref_dout = ref_mem[idx];
    exp_q.push_back({e, ref_dout});
  endtask

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_req(input string tag, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    logic [32:0] expv;
    rd = r; wr = w; dir = a; dataIn = d;
    model_req(r, w, a, d);
    tick();
    rd = 1'b0; wr = 1'b0; dir = $urandom; dataIn = $urandom;
    check({tag, ".t1_busy"}, 32'(busy), 32'd1);
    check({tag, ".t1_ack"},  32'(ack),  32'd0);
    tick();
    expv = exp_q.pop_front();
    check({tag, ".t2_ack"},     32'(ack),  32'd1);
    check({tag, ".t2_err"},     32'(err),  32'(expv[32]));
    check({tag, ".t2_dataOut"}, dataOut,   expv[31:0]);
    tick();
    check({tag, ".t3_ack"},  32'(ack),  32'd0);
    check({tag, ".t3_busy"}, 32'(busy), 32'd0);
    check({tag, ".t3_err"},  32'(err),  32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] a;
    int          kind;
    int          idx;

    ref_dout = 32'd0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; dir = 32'd0; dataIn = 32'd0;
    #1;
    check("reset.ack",     32'(ack),  32'd0);
    check("reset.busy",    32'(busy), 32'd0);
    check("reset.err",     32'(err),  32'd0);
    check("reset.dataOut", dataOut,   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle.ack", 32'(ack), 32'd0);

    // Write then read back.
    do_req("wr_8", 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    do_req("rd_8", 1'b1, 1'b0, 32'h8, 32'h0);

    // Misaligned read leaves dataOut alone.
    do_req("rd_misaligned", 1'b1, 1'b0, 32'h6, 32'h0);

    // Out-of-range write does not alias onto word 0.
    do_req("wr_0",   1'b0, 1'b1, 32'h0,   32'hA5A5_0F0F);
    do_req("wr_oor", 1'b0, 1'b1, 32'h100, 32'h1234);
    do_req("rd_0",   1'b1, 1'b0, 32'h0,   32'h0);

    // Conflicting request leaves word 1 intact.
    do_req("wr_4",       1'b0, 1'b1, 32'h4, 32'h1111_2222);
    do_req("rdwr_4",     1'b1, 1'b1, 32'h4, 32'h9999_9999);
    do_req("rd_4",       1'b1, 1'b0, 32'h4, 32'h0);

    // Request offered while busy is dropped.
    do_req("wr_10", 1'b0, 1'b1, 32'h10, 32'hCAFE_0010);
    rd = 1'b0; wr = 1'b1; dir = 32'h14; dataIn = 32'h0BAD_F00D;
    model_req(1'b0, 1'b1, 32'h14, 32'h0BAD_F00D);
    tick();
    wr = 1'b0; rd = 1'b1; dir = 32'h10;   // held across the next edge
    tick();
    rd = 1'b0;
    begin
      logic [32:0] expv;
      expv = exp_q.pop_front();
      check("drop.ack",     32'(ack), 32'd1);
      check("drop.err",     32'(err), 32'(expv[32]));
      check("drop.dataOut", dataOut,  expv[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop.no_ack",  32'(ack),  32'd0);
      check("drop.no_busy", 32'(busy), 32'd0);
    end
    check("drop.dataOut_hold", dataOut, ref_dout);
    do_req("rd_14", 1'b1, 1'b0, 32'h14, 32'h0);

    // Reset while a write sits in ACCESS.
    do_req("wr_c", 1'b0, 1'b1, 32'hC, 32'h77);
    rd = 1'b0; wr = 1'b1; dir = 32'hC; dataIn = 32'h55;
    tick();
    wr = 1'b0;
    check("rstmid.busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    ref_dout = 32'd0;
    check("rstmid.busy",    32'(busy), 32'd0);
    check("rstmid.ack",     32'(ack),  32'd0);
    check("rstmid.err",     32'(err),  32'd0);
    check("rstmid.dataOut", dataOut,   32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid.no_ack", 32'(ack), 32'd0);
    end
    do_req("rd_c", 1'b1, 1'b0, 32'hC, 32'h0);

    // Randomized mix against the model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        do_req("rnd_wr", 1'b0, 1'b1, a, $urandom);
      end else if (kind <= 7) begin
        idx = written[$urandom_range(0, written.size() - 1)];
        do_req("rnd_rd", 1'b1, 1'b0, 32'(idx) * 4, $urandom);
      end else if (kind == 8) begin
        a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        do_req("rnd_misaligned", $urandom_range(0, 1) == 1, 1'b1, a, $urandom);
      end else begin
        a = ($urandom | 32'h8000_0000) & ~32'h3;
        if ($urandom_range(0, 1) == 1)
          do_req("rnd_oor", 1'b1, 1'b0, a, $urandom);
        else
          do_req("rnd_conflict", 1'b1, 1'b1, 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
